// File: rtl/vslc_io_expander_if.sv
// Scan-side and shift-register-side signals of the VSLC serial I/O expander.
// master = core plus external 74HC595/74HC165 chain, slave = expander.
interface vslc_io_expander_if;
    logic       scan_cycle_clk;
    logic [7:0] led_in;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_valid;
    logic       busy;
    logic       overrun;
    logic       sr_clk;
    logic       sr_load_n;
    logic       sr_latch;
    logic       sr_dout;
    logic       sr_din;

    modport master (
        output scan_cycle_clk,
        output led_in,
        output sr_din,
        input  in_a,
        input  in_b,
        input  in_valid,
        input  busy,
        input  overrun,
        input  sr_clk,
        input  sr_load_n,
        input  sr_latch,
        input  sr_dout
    );

    modport slave (
        input  scan_cycle_clk,
        input  led_in,
        input  sr_din,
        output in_a,
        output in_b,
        output in_valid,
        output busy,
        output overrun,
        output sr_clk,
        output sr_load_n,
        output sr_latch,
        output sr_dout
    );
endinterface

// File: rtl/vslc_io_expander.sv
// Serial I/O expander: shifts the core's LED byte into a 74HC595 and reads
// 16 input bits from two chained 74HC165s once per scan request.
module vslc_io_expander #(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    vslc_io_expander_if.slave bus
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t        state;
    logic          scan_q;
    logic          scan_vld;
    logic          req;
    logic          half_done;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_cnt;
    logic [15:0]   tx_sr;
    logic [15:0]   rx_sr;

    // scan_vld masks the first cycle after reset so a scan level that is
    // already high when reset releases is not mistaken for a rising edge.
    assign req       = bus.scan_cycle_clk & ~scan_q & scan_vld;
    assign half_done = (cnt == CNT_LAST);

    // Scan strobe edge detector (same clock domain as the core).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q   <= 1'b0;
            scan_vld <= 1'b0;
        end else begin
            scan_q   <= bus.scan_cycle_clk;
            scan_vld <= 1'b1;
        end
    end

    // Sticky flag for requests that arrive before the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overrun <= 1'b0;
        end else if (req && state != S_IDLE) begin
            bus.overrun <= 1'b1;
        end
    end

    // Exchange sequencer: parallel load, 16 serial clocks, latch, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            bus.sr_clk    <= 1'b0;
            bus.sr_load_n <= 1'b1;
            bus.sr_latch  <= 1'b0;
            bus.sr_dout   <= 1'b0;
            bus.in_a      <= '0;
            bus.in_b      <= '0;
            bus.in_valid  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.in_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        state         <= S_LOAD;
                        tx_sr         <= {8'h00, bus.led_in};
                        rx_sr         <= '0;
                        bit_cnt       <= '0;
                        cnt           <= '0;
                        bus.sr_load_n <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (half_done) begin
                        state         <= S_SHIFT;
                        cnt           <= '0;
                        bit_cnt       <= '0;
                        bus.sr_load_n <= 1'b1;
                        bus.sr_clk    <= 1'b0;
                        bus.sr_dout   <= tx_sr[15];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (!half_done) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        if (!bus.sr_clk) begin
                            // QH still shows the pre-shift bit on this edge.
                            bus.sr_clk <= 1'b1;
                            rx_sr      <= {rx_sr[14:0], bus.sr_din};
                        end else if (bit_cnt == 5'd15) begin
                            bus.sr_clk   <= 1'b0;
                            bus.sr_latch <= 1'b1;
                            bit_cnt      <= '0;
                            state        <= S_LATCH;
                        end else begin
                            // Next SER bit changes only with the falling edge.
                            bus.sr_clk  <= 1'b0;
                            bit_cnt     <= bit_cnt + 5'd1;
                            tx_sr       <= {tx_sr[14:0], 1'b0};
                            bus.sr_dout <= tx_sr[14];
                        end
                    end
                end
                S_LATCH: begin
                    if (half_done) begin
                        state        <= S_DONE;
                        cnt          <= '0;
                        bit_cnt      <= '0;
                        bus.sr_latch <= 1'b0;
                        bus.in_a     <= rx_sr[15:8];
                        bus.in_b     <= rx_sr[7:0];
                        bus.in_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    bit_cnt  <= '0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/vslc_io_expander.md
# vslc_io_expander

Serial I/O expander at the far end of the VSLC core's scan interface. It consumes the core's scan strobe and LED/output byte, shifts that byte out to an external 74HC595 and reads 16 input bits from two chained 74HC165s. It then presents those bits as the two 8-bit input bytes the core samples on its next scan. It sits beside the core inside the top-level wrapper, between the core and the `uo_out`/`ui_in` pins.

## Interface
- `CLK_DIV`, default 4, sets the `clk` cycles per serial-clock half-period. The minimum is 1.
- `clk` in 1: system clock. It is the same domain as the core.
- `rst_n` in 1: reset, asynchronous, active-low.
- `scan_cycle_clk` in 1: the core's scan clock. A rising edge requests one exchange.
- `led_in` in 8: the core's output byte. It is sampled at the request.
- `in_a` out 8: first deserialised input byte, to the core's first 8-bit input port.
- `in_b` out 8: second deserialised input byte, to the core's second 8-bit input port.
- `in_valid` out 1: one-cycle pulse when `in_a`/`in_b` update.
- `busy` out 1: high while an exchange is in progress.
- `overrun` out 1: sticky flag, set when a request arrives while busy.
- `sr_clk` out 1: shared SRCLK for the 595 and the 165s.
- `sr_load_n` out 1: 165 SH/LD_n, active-low parallel load.
- `sr_latch` out 1: 595 RCLK.
- `sr_dout` out 1: 595 SER.
- `sr_din` in 1: QH of the 165 chain.

## Operation
- Edge detect: register `scan_cycle_clk` into `scan_q`; request = `scan_cycle_clk & ~scan_q`. No synchroniser is needed (same domain).
- FSM states:
  - IDLE: on a request, capture the 16-bit frame {8'h00, `led_in`} into the TX shift register, clear the RX register and bit counter, and go to LOAD.
  - LOAD: hold `sr_load_n`=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 serial-clock periods, each with a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
    - `sr_dout` presents the frame MSB first, stable for the whole period.
    - `sr_din` is sampled on the `clk` edge where `sr_clk` goes 0→1, and shifted into the RX register LSB-side. The first sampled bit is `in_a[7]` and the 16th is `in_b[0]`.
    - After the 16th high phase, go to LATCH.
  - LATCH: `sr_latch`=1 for CLK_DIV cycles, then go to DONE.
  - DONE: load `in_a`←RX[15:8] and `in_b`←RX[7:0], assert `in_valid` for 1 cycle, then return to IDLE.
- `busy`=1 in every state except IDLE.
- Because the first 8 frame bits are zero padding, after 16 clocks the 595 holds `led_in`.
- `led_in` changes after the capture cycle have no effect on the exchange in progress.
- A request seen while `busy`=1 is dropped and sets `overrun`. `overrun` is cleared only by reset.
- A request that coincides with DONE is also dropped and sets `overrun`. IDLE must be reached first.
- The serial-clock half-period counter and the 5-bit bit counter are both reset on entry to each state.

## Timing
- Reset values, applied immediately and asynchronously:
  - `sr_clk`=0, `sr_load_n`=1, `sr_latch`=0, `sr_dout`=0.
  - `in_a`=`in_b`=8'h00, `in_valid`=0, `busy`=0, `overrun`=0.
  - FSM=IDLE, `scan_q`=0.
- Latency: the request is detected in cycle T.
  - `busy` rises at T+1.
  - `sr_load_n` is low over T+1..T+CLK_DIV.
  - SHIFT occupies 32·CLK_DIV cycles.
  - LATCH occupies CLK_DIV cycles.
  - `in_valid` pulses at T+34·CLK_DIV+1.
  - `busy` falls at T+34·CLK_DIV+2.
- The minimum request spacing without overrun is 34·CLK_DIV+2 cycles.
- `sr_dout` changes only in the cycle `sr_clk` falls, or on entry to SHIFT. This guarantees ≥CLK_DIV cycles of setup and hold around each rising edge.
- `sr_clk` idles low, and is low throughout LOAD, LATCH and DONE.
- `in_a`/`in_b` hold their previous values until DONE. An aborted exchange never updates them.
- Reset mid-exchange aborts the exchange. The 595 register keeps its last latched value, and the next request after reset runs a clean exchange.

## Test plan
- **Reset values:** hold `rst_n`=0 with random inputs → all outputs at their reset values. Then release `rst_n` with `scan_cycle_clk`=1 already high → no exchange starts until a fresh 0→1 edge.
- **Single exchange:** CLK_DIV=2, `led_in`=8'hA5, 165 model loaded with `in_a`=8'h3C and `in_b`=8'hC3, request at T.
  - 595 model outputs 8'hA5 after `sr_latch`.
  - `in_a`=8'h3C, `in_b`=8'hC3.
  - `in_valid` pulses exactly at T+69.
  - Exactly 16 `sr_clk` rising edges occur.
- **Stale `led_in`:** change `led_in` from 8'h0F to 8'hF0 during SHIFT → the 595 latches 8'h0F. The next exchange latches 8'hF0.
- **Overrun:** issue a second request 20 cycles after the first (CLK_DIV=2).
  - The second request is ignored and `overrun`=1 stays set.
  - The first exchange completes unchanged.
  - A third request after `busy` falls completes normally.
- **Reset mid-SHIFT:** assert `rst_n`=0 after 5 serial clocks → all outputs return to reset values at once. The next request yields correct `in_a`/`in_b`.
- **Back-to-back at minimum spacing:** CLK_DIV=1, requests every 36 cycles for 4 scans with distinct patterns → `overrun` stays 0, and every `in_valid` carries the correct bytes.
